// File: rtl/count_monitor.sv
// Checks that a sampled counter steps by one in the expected direction, locks after LOCK_N good steps.
// Optional build macro COUNT_MONITOR_STALL_EN: a repeated value is treated as a stall, not an error.
module count_monitor #(
  parameter int BITS   = 4,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_en,
  input  logic             dir,
  input  logic [BITS-1:0]  count_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BITS-1:0]  last_count
);

  typedef enum logic [1:0] {EMPTY, HUNT, LOCK} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       good_reg, good_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic [BITS-1:0]  last_count_reg, last_count_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             locked_reg;

  logic [BITS-1:0]  expected;
  logic [4:0]       good_inc;
  logic             match;
  logic             stall;

  assign expected = dir ? (last_count_reg + BITS'(1)) : (last_count_reg - BITS'(1));
  assign match    = (count_in == expected);
  assign good_inc = {1'b0, good_reg} + 5'd1;

`ifdef COUNT_MONITOR_STALL_EN
  assign stall = (count_in == last_count_reg);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    good_next       = good_reg;
    err_count_next  = err_count_reg;
    last_count_next = last_count_reg;
    err_pulse_next  = 1'b0;
    if (clr) begin
      // last_count deliberately survives a clear
      state_next     = EMPTY;
      good_next      = 4'd0;
      err_count_next = '0;
    end else if (sample_en) begin
      last_count_next = count_in;
      unique case (state_reg)
        EMPTY: begin
          good_next  = 4'd0;
          state_next = HUNT;
        end
        HUNT: begin
          if (!stall) begin
            if (match) begin
              if (good_inc >= 5'(LOCK_N)) begin
                good_next  = 4'd0;
                state_next = LOCK;
              end else begin
                good_next = good_inc[3:0];
              end
            end else begin
              good_next = 4'd0;
            end
          end
        end
        LOCK: begin
          if (!stall && !match) begin
            err_pulse_next = 1'b1;
            good_next      = 4'd0;
            state_next     = HUNT;
            if (err_count_reg != {ERR_W{1'b1}})
              err_count_next = err_count_reg + ERR_W'(1);
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      good_reg       <= 4'd0;
      err_count_reg  <= '0;
      last_count_reg <= '0;
      err_pulse_reg  <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      good_reg       <= good_next;
      err_count_reg  <= err_count_next;
      last_count_reg <= last_count_next;
      err_pulse_reg  <= err_pulse_next;
      locked_reg     <= (state_next == LOCK);
    end
  end

  assign locked     = locked_reg;
  assign err_pulse  = err_pulse_reg;
  assign err_count  = err_count_reg;
  assign last_count = last_count_reg;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: two instances (ERR_W=8 and ERR_W=2) share stimulus
// and are compared every cycle against a sample-history reference model.
module tb_count_monitor;

  localparam int BITS = 4;
  localparam int LOCK_N = 4;
  localparam int MOD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic sample_en = 1'b0;
  logic dir = 1'b1;
  logic [BITS-1:0] count_in = '0;
  logic locked_a, err_pulse_a, locked_b, err_pulse_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;
  logic [BITS-1:0] last_count_a, last_count_b;

  count_monitor #(.BITS(BITS), .LOCK_N(LOCK_N), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sample_en(sample_en), .dir(dir),
    .count_in(count_in), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_count(err_count_a), .last_count(last_count_a));

  count_monitor #(.BITS(BITS), .LOCK_N(LOCK_N), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sample_en(sample_en), .dir(dir),
    .count_in(count_in), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_count(err_count_b), .last_count(last_count_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: lock status, raw (unsaturated) error total, run of good steps
  bit m_active, m_locked, m_pulse;
  int m_err, m_run, m_last;

  function automatic logic [15:0] model_vec();
    int ea, eb;
    ea = (m_err > 255) ? 255 : m_err;
    eb = (m_err > 3) ? 3 : m_err;
    return {m_locked, m_pulse, 8'(ea), 2'(eb), 4'(m_last)};
  endfunction

  wire [15:0] obs_a = {locked_a, err_pulse_a, err_count_a, 2'(0), last_count_a};
  wire [15:0] obs_b = {locked_b, err_pulse_b, 8'(0), err_count_b, last_count_b};

  function automatic logic [15:0] model_a();
    logic [15:0] v;
    v = model_vec();
    v[5:4] = 2'b00;
    return v;
  endfunction

  function automatic logic [15:0] model_b();
    logic [15:0] v;
    v = model_vec();
    v[13:6] = 8'h00;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_pulse = 0; m_err = 0; m_run = 0; m_last = 0;
  endtask

  task automatic model_edge(bit c, bit se, bit d, int ci);
    int exp_v;
    bit st;
    m_pulse = 0;
    if (c) begin
      m_active = 0; m_locked = 0; m_err = 0; m_run = 0;
      return;
    end
    if (!se) return;
    if (!m_active) begin
      m_active = 1; m_run = 0; m_last = ci;
      return;
    end
    exp_v = (m_last + (d ? 1 : MOD - 1)) % MOD;
`ifdef COUNT_MONITOR_STALL_EN
    st = (ci == m_last);
`else
    st = 0;
`endif
    if (!st) begin
      if (ci == exp_v) begin
        if (!m_locked) begin
          m_run++;
          if (m_run >= LOCK_N) begin m_locked = 1; m_run = 0; end
        end
      end else begin
        if (m_locked) begin m_pulse = 1; m_err++; end
        m_locked = 0; m_run = 0;
      end
    end
    m_last = ci;
  endtask

  task automatic step(bit c, bit se, bit d, int ci);
    clr = c; sample_en = se; dir = d; count_in = 4'(ci);
    @(posedge clk);
    model_edge(c, se, d, ci);
    #1;
    $display("txn clr=%0d se=%0d dir=%0d cin=%h -> locked=%0d pulse=%0d err=%0d/%0d last=%h",
             c, se, d, 4'(ci), locked_a, err_pulse_a, err_count_a, err_count_b, last_count_a);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    n_checks++;
    if ({obs_a, obs_b} !== {model_a(), model_b()})
      $display("FAIL reset: got %h/%h expected %h/%h", obs_a, obs_b, model_a(), model_b());
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_lock_up();
    int seq[5] = '{3, 4, 5, 6, 7};
    foreach (seq[i]) begin
      step(0, 1, 1, seq[i]);
      n_checks++;
      if (obs_a !== model_a() || locked_a !== (i == 4))
        $display("FAIL lock_up[%0d]: got %h expected %h", i, obs_a, model_a());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int up[10] = '{8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
    int dn[3] = '{0, 15, 14};
    foreach (up[i]) begin
      step(0, 1, 1, up[i]);
      n_checks++;
      if (obs_a !== model_a() || locked_a !== 1'b1 || err_pulse_a !== 1'b0)
        $display("FAIL wrap_up[%0d]: got %h expected %h", i, obs_a, model_a());
      else n_pass++;
    end
    foreach (dn[i]) begin
      step(0, 1, 0, dn[i]);
      n_checks++;
      if (obs_a !== model_a() || locked_a !== 1'b1 || err_count_a !== 8'd0)
        $display("FAIL wrap_dn[%0d]: got %h expected %h", i, obs_a, model_a());
      else n_pass++;
    end
  endtask

  task automatic test_error_relock();
    int pre[5] = '{1, 2, 3, 4, 5};
    int post[4] = '{10, 11, 12, 13};
    step(1, 0, 1, 0);
    foreach (pre[i]) step(0, 1, 1, pre[i]);
    step(0, 1, 1, 9);
    n_checks++;
    if (obs_a !== model_a() || {locked_a, err_pulse_a, err_count_a, last_count_a} !== {2'b01, 8'd1, 4'd9})
      $display("FAIL error_detect: got %h expected %h", obs_a, model_a());
    else n_pass++;
    step(0, 0, 1, 0);
    n_checks++;
    if (err_pulse_a !== 1'b0 || err_count_a !== 8'd1)
      $display("FAIL error_pulse_width: got %0d/%0d expected 0/1", err_pulse_a, err_count_a);
    else n_pass++;
    foreach (post[i]) step(0, 1, 1, post[i]);
    n_checks++;
    if (obs_a !== model_a() || locked_a !== 1'b1)
      $display("FAIL relock: got %h expected %h", obs_a, model_a());
    else n_pass++;
  endtask

  task automatic test_saturation();
    int v;
    v = 13;
    for (int r = 0; r < 4; r++) begin
      v = (v + 5) % MOD;
      step(0, 1, 1, v);
      n_checks++;
      if (obs_b !== model_b() || err_pulse_b !== 1'b1 || obs_a !== model_a())
        $display("FAIL saturate_err[%0d]: got %h expected %h", r, obs_b, model_b());
      else n_pass++;
      for (int k = 0; k < LOCK_N; k++) begin v = (v + 1) % MOD; step(0, 1, 1, v); end
    end
    n_checks++;
    if (err_count_b !== 2'd3 || err_count_a !== 8'd5)
      $display("FAIL saturate_final: got %0d/%0d expected 3/5", err_count_b, err_count_a);
    else n_pass++;
  endtask

  task automatic test_stall();
    int seq[5] = '{2, 3, 4, 5, 6};
    step(1, 0, 1, 0);
    foreach (seq[i]) step(0, 1, 1, seq[i]);
    step(0, 1, 1, 6);
    n_checks++;
`ifdef COUNT_MONITOR_STALL_EN
    if (obs_a !== model_a() || err_pulse_a !== 1'b0 || locked_a !== 1'b1)
`else
    if (obs_a !== model_a() || err_pulse_a !== 1'b1 || err_count_a !== 8'd1)
`endif
      $display("FAIL stall: got %h expected %h", obs_a, model_a());
    else n_pass++;
  endtask

  task automatic test_clr_collision();
    int seq[5] = '{7, 8, 9, 10, 11};
    foreach (seq[i]) step(0, 1, 1, seq[i]);
    step(0, 1, 1, 3);
    foreach (seq[i]) step(0, 1, 1, seq[i]);
    step(1, 1, 1, 12);
    n_checks++;
    if (obs_a !== model_a() || {locked_a, err_count_a, last_count_a} !== {1'b0, 8'd0, 4'd11})
      $display("FAIL clr_collision: got %h expected %h", obs_a, model_a());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    step(0, 1, 1, 4);
    step(0, 1, 1, 5);
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({obs_a, obs_b} !== {model_a(), model_b()} || last_count_a !== 4'd0)
      $display("FAIL mid_reset: got %h expected %h", obs_a, model_a());
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 0, 9);
    step(0, 1, 0, 8);
    n_checks++;
    if (obs_a !== model_a() || last_count_a !== 4'd8)
      $display("FAIL post_reset: got %h expected %h", obs_a, model_a());
    else n_pass++;
  endtask

  task automatic test_random();
    int ci;
    bit c, se, d;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 39) == 0);
      se = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0, 1:    ci = $urandom_range(0, MOD - 1);
        2:       ci = m_last;
        default: ci = (m_last + (d ? 1 : MOD - 1)) % MOD;
      endcase
      step(c, se, d, ci);
      n_checks++;
      if ({obs_a, obs_b} !== {model_a(), model_b()})
        $display("FAIL random[%0d]: got %h/%h expected %h/%h", n, obs_a, obs_b, model_a(), model_b());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_up();
    test_wrap();
    test_error_relock();
    test_saturation();
    test_stall();
    test_clr_collision();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
